// File: rtl/ray_column_scheduler.sv
`default_nettype none
// ============================================================================
// ray_column_scheduler: issues one ray per column each frame, writes results
// into the back buffer and swaps banks on the frame tick.  Revision 1.0
// ============================================================================
module ray_column_scheduler #(
  parameter int NUM_COLS = 640,
  parameter int COL_W    = 10,
  parameter int H_W      = 9,
  parameter int MAX_H    = 480
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               frame_tick,
  output logic               ray_valid,
  output logic [COL_W-1:0]   ray_col,
  input  logic               ray_ready,
  input  logic               res_valid,
  input  logic [H_W-1:0]     res_height,
  input  logic               res_side,
  output logic               wr_en,
  output logic [COL_W:0]     wr_addr,
  output logic [H_W:0]       wr_data,
  output logic               rd_bank,
  output logic               busy,
  output logic               overrun,
  output logic [7:0]         frame_count
);

  localparam logic [COL_W-1:0] LAST_COL = COL_W'(NUM_COLS - 1);
  localparam logic [H_W-1:0]   MAX_H_V  = H_W'(MAX_H);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             state, state_n;
  logic [COL_W-1:0]   col, col_n;
  logic               ray_valid_n;
  logic [COL_W-1:0]   ray_col_n;
  logic               wr_en_n;
  logic [COL_W:0]     wr_addr_n;
  logic [H_W:0]       wr_data_n;
  logic               rd_bank_n;
  logic               busy_n;
  logic               overrun_n;
  logic [7:0]         frame_count_n;
  logic [H_W-1:0]     clamped;

  assign clamped = (res_height > MAX_H_V) ? MAX_H_V : res_height;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= S_IDLE;
      col         <= '0;
      ray_valid   <= 1'b0;
      ray_col     <= '0;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      rd_bank     <= 1'b0;
      busy        <= 1'b0;
      overrun     <= 1'b0;
      frame_count <= '0;
    end else begin
      state       <= state_n;
      col         <= col_n;
      ray_valid   <= ray_valid_n;
      ray_col     <= ray_col_n;
      wr_en       <= wr_en_n;
      wr_addr     <= wr_addr_n;
      wr_data     <= wr_data_n;
      rd_bank     <= rd_bank_n;
      busy        <= busy_n;
      overrun     <= overrun_n;
      frame_count <= frame_count_n;
    end
  end

  always_comb begin
    state_n       = state;
    col_n         = col;
    ray_valid_n   = ray_valid;
    ray_col_n     = ray_col;
    wr_en_n       = 1'b0;
    wr_addr_n     = wr_addr;
    wr_data_n     = wr_data;
    rd_bank_n     = rd_bank;
    overrun_n     = overrun;
    frame_count_n = frame_count;

    case (state)
      S_IDLE: begin
        if (frame_tick && start) begin
          state_n     = S_ISSUE;
          col_n       = '0;
          ray_valid_n = 1'b1;
          ray_col_n   = '0;
        end
      end
      S_ISSUE: begin
        if (frame_tick) overrun_n = 1'b1;
        if (ray_ready) begin
          state_n     = S_WAIT;
          ray_valid_n = 1'b0;
        end
      end
      S_WAIT: begin
        if (frame_tick) overrun_n = 1'b1;
        if (res_valid) begin
          // The write bank is the one the display is not reading.
          wr_en_n   = 1'b1;
          wr_addr_n = {~rd_bank, col};
          wr_data_n = {res_side, clamped};
          if (col == LAST_COL) begin
            state_n = S_DONE;
          end else begin
            state_n     = S_ISSUE;
            col_n       = col + COL_W'(1);
            ray_valid_n = 1'b1;
            ray_col_n   = col + COL_W'(1);
          end
        end
      end
      S_DONE: begin
        if (frame_tick) begin
          rd_bank_n     = ~rd_bank;
          frame_count_n = frame_count + 8'd1;
          if (start) begin
            state_n     = S_ISSUE;
            col_n       = '0;
            ray_valid_n = 1'b1;
            ray_col_n   = '0;
          end else begin
            state_n = S_IDLE;
          end
        end
      end
      default: begin
        state_n     = S_IDLE;
        ray_valid_n = 1'b0;
      end
    endcase

    busy_n = (state_n == S_ISSUE) || (state_n == S_WAIT);
  end

endmodule
`default_nettype wire

// File: tb/tb_ray_column_scheduler.sv
`default_nettype none
// ============================================================================
// tb_ray_column_scheduler: randomized raycaster stub plus event-level model.
// Revision 1.0
// ============================================================================
module tb_ray_column_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        frame_tick = 1'b0;
  logic        ray_ready = 1'b0;
  logic        res_valid = 1'b0;
  logic [8:0]  res_height = '0;
  logic        res_side = 1'b0;
  logic        ray_valid;
  logic [9:0]  ray_col;
  logic        wr_en;
  logic [10:0] wr_addr;
  logic [9:0]  wr_data;
  logic        rd_bank;
  logic        busy;
  logic        overrun;
  logic [7:0]  frame_count;

  ray_column_scheduler dut (
    .clk(clk), .rst(rst), .start(start), .frame_tick(frame_tick),
    .ray_valid(ray_valid), .ray_col(ray_col), .ray_ready(ray_ready),
    .res_valid(res_valid), .res_height(res_height), .res_side(res_side),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_bank(rd_bank), .busy(busy), .overrun(overrun), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  // knobs written by the scenario process only
  logic rst_lvl = 1'b0;
  logic start_lvl = 1'b0;
  int   tick_req = 0;
  int   stray_req = 0;
  int   ready_mode = 0;   // 0 always ready, 1 random, 2 never
  int   lat_mode = 0;     // 0 zero latency, 1 random 0..3, 2 fixed 3
  int   force_mode = 0;   // 0 random height, 1 500/side1, 2 479/side0

  // driver-owned state
  int   tick_seen = 0;
  int   stray_seen = 0;
  int   res_pend = 0;
  int   res_cnt = 0;

  // behavioural model of the frame sequencer
  logic        m_req = 1'b0;
  logic        m_wait = 1'b0;
  logic        m_done = 1'b0;
  int          m_col = 0;
  logic        m_rd_bank = 1'b0;
  int          m_fc = 0;
  logic        m_ovr = 1'b0;
  logic        exp_zero = 1'b1;
  logic        exp_wr_en = 1'b0;
  logic [10:0] exp_wr_addr = '0;
  logic [9:0]  exp_wr_data = '0;

  int checks = 0;
  int failures = 0;
  int wr_cnt = 0;
  int bank_cnt [2] = '{0, 0};
  logic [9:0] last_wr_data = '0;

  function automatic int pick_lat();
    if (lat_mode == 1) return int'($urandom_range(0, 3));
    if (lat_mode == 2) return 3;
    return 0;
  endfunction

  task automatic model_step();
    exp_wr_en = 1'b0;
    if (!rst) begin
      m_req = 0; m_wait = 0; m_done = 0; m_col = 0;
      m_rd_bank = 0; m_fc = 0; m_ovr = 0;
      exp_zero = 1; exp_wr_addr = '0; exp_wr_data = '0;
      res_pend = 0;
      return;
    end
    exp_zero = 0;
    if (m_req) begin
      if (frame_tick) m_ovr = 1;
      if (ray_ready) begin
        m_req = 0; m_wait = 1;
        res_pend = 1; res_cnt = pick_lat();
      end
    end else if (m_wait) begin
      if (frame_tick) m_ovr = 1;
      if (res_valid) begin
        exp_wr_en   = 1;
        exp_wr_addr = {~m_rd_bank, 10'(m_col)};
        exp_wr_data = {res_side, (res_height > 9'd480) ? 9'd480 : res_height};
        if (m_col == 639) begin
          m_wait = 0; m_done = 1;
        end else begin
          m_col = m_col + 1; m_req = 1;
        end
      end
    end else if (m_done) begin
      if (frame_tick) begin
        m_rd_bank = ~m_rd_bank;
        m_fc = (m_fc + 1) % 256;
        m_done = 0;
        if (start) begin m_col = 0; m_req = 1; end
      end
    end else if (frame_tick && start) begin
      m_col = 0; m_req = 1;
    end
  endtask

  // Model update on the edge, then drive the next cycle's inputs.
  always @(posedge clk) begin
    model_step();
    #1;
    rst   = rst_lvl;
    start = start_lvl;
    frame_tick = (tick_seen != tick_req);
    if (frame_tick) tick_seen++;
    ray_ready = (ready_mode == 0) ? 1'b1 : (ready_mode == 1) ? 1'($urandom % 2) : 1'b0;
    res_valid = 1'b0;
    if (res_pend != 0) begin
      if (res_cnt == 0) begin
        res_pend = 0;
        res_valid = 1'b1;
        if (force_mode == 1) begin res_height = 9'd500; res_side = 1'b1; end
        else if (force_mode == 2) begin res_height = 9'd479; res_side = 1'b0; end
        else begin res_height = 9'($urandom_range(0, 511)); res_side = 1'($urandom % 2); end
      end else begin
        res_cnt--;
      end
    end
    if (stray_seen != stray_req) begin
      stray_seen++;
      res_valid = 1'b1;
      res_height = 9'($urandom_range(0, 511));
      res_side = 1'b1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic compare_all();
    chk("ray_valid", 32'(ray_valid), 32'(m_req));
    if (m_req) chk("ray_col", 32'(ray_col), 32'(m_col));
    chk("wr_en", 32'(wr_en), 32'(exp_wr_en));
    if (exp_wr_en) begin
      chk("wr_addr", 32'(wr_addr), 32'(exp_wr_addr));
      chk("wr_data", 32'(wr_data), 32'(exp_wr_data));
    end
    if (exp_zero) begin
      chk("rst_ray_col", 32'(ray_col), 0);
      chk("rst_wr_addr", 32'(wr_addr), 0);
      chk("rst_wr_data", 32'(wr_data), 0);
    end
    chk("rd_bank", 32'(rd_bank), 32'(m_rd_bank));
    chk("busy", 32'(busy), 32'(m_req | m_wait));
    chk("overrun", 32'(overrun), 32'(m_ovr));
    chk("frame_count", 32'(frame_count), 32'(m_fc));
    if (wr_en) begin
      wr_cnt++;
      bank_cnt[wr_addr[10]]++;
      last_wr_data = wr_data;
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      compare_all();
    end
  endtask

  task automatic wait_frame_done(input string name, input int budget);
    int n = 0;
    while (!m_done && n < budget) begin step(1); n++; end
    chk(name, 32'(n < budget), 1);
  endtask

  task automatic wait_write(input string name);
    int n = 0;
    int w = wr_cnt;
    while (wr_cnt == w && n < 20) begin step(1); n++; end
    chk(name, 32'(n < 20), 1);
  endtask

  initial begin
    int n;
    int w;
    int b0;
    int b1;

    // 1: reset held with start and ticks
    rst_lvl = 0; start_lvl = 1;
    step(2); tick_req++; step(3); tick_req++; step(3);
    chk("reset_ray_valid", 32'(ray_valid), 0);
    chk("reset_rd_bank", 32'(rd_bank), 0);
    chk("reset_frame_count", 32'(frame_count), 0);
    chk("reset_overrun", 32'(overrun), 0);
    rst_lvl = 1; step(3);
    tick_req++;
    n = 0;
    while (!ray_valid && n < 10) begin step(1); n++; end
    chk("tick_to_valid_cycles", n, 2);
    chk("first_ray_col", 32'(ray_col), 0);

    // 2: full frame, zero-latency raycaster
    b0 = bank_cnt[0]; b1 = bank_cnt[1];
    wait_frame_done("frame1_complete", 5000);
    chk("frame1_bank1_writes", bank_cnt[1] - b1, 640);
    chk("frame1_bank0_writes", bank_cnt[0] - b0, 0);
    tick_req++; step(3);
    chk("swap1_rd_bank", 32'(rd_bank), 1);
    chk("swap1_frame_count", 32'(frame_count), 1);
    b0 = bank_cnt[0]; b1 = bank_cnt[1];
    wait_frame_done("frame2_complete", 5000);
    chk("frame2_bank0_writes", bank_cnt[0] - b0, 640);
    chk("frame2_bank1_writes", bank_cnt[1] - b1, 0);

    // 3: clamp boundaries, then randomized handshake timing
    force_mode = 1; tick_req++;
    wait_write("clamp500_write_seen");
    chk("clamp500_data", 32'(last_wr_data), 32'h3E0);
    force_mode = 2;
    wait_write("h479_write_seen");
    chk("h479_data", 32'(last_wr_data), 32'h1DF);
    force_mode = 0; ready_mode = 1; lat_mode = 1;
    wait_frame_done("frame3_complete", 20000);

    // 4: overrun with ray_ready stuck low
    ready_mode = 2; lat_mode = 0;
    tick_req++; step(4);
    tick_req++; step(4);
    chk("overrun_set", 32'(overrun), 1);
    chk("overrun_rd_bank_held", 32'(rd_bank), 1);
    chk("overrun_frame_count_held", 32'(frame_count), 3);

    // 5: backpressure stability and stray result during ISSUE
    for (int i = 0; i < 5; i++) begin
      step(1);
      chk("bp_ray_valid", 32'(ray_valid), 1);
      chk("bp_ray_col", 32'(ray_col), 0);
    end
    w = wr_cnt; stray_req++; step(4);
    chk("stray_issue_no_write", wr_cnt - w, 0);
    ready_mode = 0;
    wait_frame_done("frame4_complete", 5000);
    tick_req++; step(3);
    chk("post_overrun_frame_count", 32'(frame_count), 4);
    chk("post_overrun_rd_bank", 32'(rd_bank), 0);

    // 6: reset while waiting on column 300
    lat_mode = 2;
    n = 0;
    while (!(m_wait && m_col == 300) && n < 5000) begin step(1); n++; end
    chk("reach_col300", 32'(n < 5000), 1);
    rst_lvl = 0; step(3);
    rst_lvl = 1; step(2);
    w = wr_cnt; stray_req++; step(4);
    chk("stray_after_reset_no_write", wr_cnt - w, 0);
    chk("midreset_rd_bank", 32'(rd_bank), 0);
    chk("midreset_busy", 32'(busy), 0);
    chk("midreset_overrun", 32'(overrun), 0);
    lat_mode = 0; start_lvl = 1; tick_req++; step(3);
    start_lvl = 0;
    wait_frame_done("frame5_complete", 5000);
    tick_req++; step(3);
    chk("stop_rd_bank", 32'(rd_bank), 1);
    chk("stop_frame_count", 32'(frame_count), 1);
    chk("stop_busy", 32'(busy), 0);
    tick_req++; step(4);
    chk("stop_stays_idle", 32'(ray_valid), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
